// File: rtl/net_bus_fifo_rd_ctrl.sv
// rtl/net_bus_fifo_rd_ctrl.sv - read-side controller for the NetBus asynchronous FIFO
//
// Purpose: synchronizes the write pointer into the read clock domain, computes
// EMPTY/LEVEL, drives the memory read address, and hides the memory's one-cycle
// registered read latency behind a two-slot (output + skid) buffer so the
// consumer sees a valid/ready stream at one word per cycle.
//
// Ports:
//   CLK        read-domain clock (same clock as the memory read port)
//   RST_N      asynchronous active-low reset
//   WPTR_GRAY  Gray write pointer from the write domain (unsynchronized)
//   RPTR_GRAY  registered Gray read pointer to the write domain
//   RADDR      memory read address (low bits of the binary read pointer)
//   RDATA      memory read data, valid the cycle after a fetch
//   DOUT       head-of-stream data
//   DVALID     DOUT holds a valid word
//   DREADY     consumer accepts DOUT (pop = DVALID & DREADY)
//   EMPTY      no unfetched words remain in memory
//   LEVEL      number of unfetched words in memory
module net_bus_fifo_rd_ctrl #(
    parameter int RAM_WIDTH = 16,
    parameter int RAM_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [RAM_DEPTH:0]   WPTR_GRAY,
    output logic [RAM_DEPTH:0]   RPTR_GRAY,
    output logic [RAM_DEPTH-1:0] RADDR,
    input  logic [RAM_WIDTH-1:0] RDATA,
    output logic [RAM_WIDTH-1:0] DOUT,
    output logic                 DVALID,
    input  logic                 DREADY,
    output logic                 EMPTY,
    output logic [RAM_DEPTH:0]   LEVEL
);

    localparam int PW = RAM_DEPTH + 1;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0]        wsync1_q, wsync2_q;
    logic [PW-1:0]        wsync_bin;
    logic [PW-1:0]        rbin_q, rbin_d;
    logic [PW-1:0]        rptr_gray_q;
    logic                 empty_q;
    logic [PW-1:0]        level_q;
    logic [RAM_WIDTH-1:0] dout_q, dout_d;
    logic                 dvalid_q, dvalid_d;
    logic [RAM_WIDTH-1:0] skid_q, skid_d;
    logic                 skid_v_q, skid_v_d;
    logic                 infl_q;
    logic [1:0]           occ;
    logic [1:0]           committed;
    logic                 pop;
    logic                 fetch;

    assign wsync_bin = gray2bin(wsync2_q);

    // Words held plus the word already on its way from memory; a pop this
    // cycle frees one slot, so a fetch may be issued in the same cycle.
    assign occ       = {1'b0, dvalid_q} + {1'b0, skid_v_q};
    assign committed = occ + {1'b0, infl_q};
    assign pop       = dvalid_q & DREADY;
    assign fetch     = ~empty_q & ((committed - {1'b0, pop}) < 2'd2);

    assign rbin_d = fetch ? rbin_q + 1'b1 : rbin_q;

    // Storage update. The skid is only ever valid while DOUT is valid, so an
    // arriving word goes to DOUT exactly when DOUT is (or becomes) free and
    // the skid holds nothing older.
    always_comb begin
        dout_d   = dout_q;
        dvalid_d = dvalid_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (pop) begin
            if (skid_v_q) begin
                dout_d = skid_q;
                if (infl_q) begin
                    skid_d = RDATA;
                end else begin
                    skid_v_d = 1'b0;
                end
            end else if (infl_q) begin
                dout_d = RDATA;
            end else begin
                dvalid_d = 1'b0;
            end
        end else if (infl_q) begin
            if (!dvalid_q) begin
                dout_d   = RDATA;
                dvalid_d = 1'b1;
            end else begin
                skid_d   = RDATA;
                skid_v_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wsync1_q    <= '0;
            wsync2_q    <= '0;
            rbin_q      <= '0;
            rptr_gray_q <= '0;
            empty_q     <= 1'b1;
            level_q     <= '0;
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            skid_q      <= '0;
            skid_v_q    <= 1'b0;
            infl_q      <= 1'b0;
        end else begin
            wsync1_q    <= WPTR_GRAY;
            wsync2_q    <= wsync1_q;
            rbin_q      <= rbin_d;
            rptr_gray_q <= rbin_d ^ (rbin_d >> 1);
            // Status is computed against the next read pointer so that a
            // fetch of the last word blocks any further fetch immediately.
            empty_q     <= (rbin_d == wsync_bin);
            level_q     <= wsync_bin - rbin_d;
            dout_q      <= dout_d;
            dvalid_q    <= dvalid_d;
            skid_q      <= skid_d;
            skid_v_q    <= skid_v_d;
            infl_q      <= fetch;
        end
    end

    assign RPTR_GRAY = rptr_gray_q;
    assign RADDR     = rbin_q[RAM_DEPTH-1:0];
    assign DOUT      = dout_q;
    assign DVALID    = dvalid_q;
    assign EMPTY     = empty_q;
    assign LEVEL     = level_q;

endmodule

// File: doc/net_bus_fifo_rd_ctrl.md
# net_bus_fifo_rd_ctrl

Read-side controller for the NetBus asynchronous FIFO, living entirely in the read clock domain. It sits directly downstream of the dual-clock FIFO memory. It synchronizes the write pointer, computes empty and level, drives the memory read address, and absorbs the memory's one-cycle registered read latency. It presents a valid/ready stream to the consumer at one word per cycle sustained.

## Interface
- RAM_WIDTH, 16, data word width; must match the FIFO memory.
- RAM_DEPTH, 4, address bits; the memory holds 2^RAM_DEPTH words and the pointers are RAM_DEPTH+1 bits.

Ports:
- CLK  in  1  read-domain clock; the same clock that drives the memory CLKR.
- RST_N  in  1  asynchronous, active-low reset.
- WPTR_GRAY  in  RAM_DEPTH+1  Gray-coded write pointer from the write domain, unsynchronized.
- RPTR_GRAY  out  RAM_DEPTH+1  registered Gray-coded read pointer, sent to the write domain.
- RADDR  out  RAM_DEPTH  memory read address; equals rbin[RAM_DEPTH-1:0], driven straight from the register.
- RDATA  in  RAM_WIDTH  memory DOUT; valid in the cycle after a fetch.
- DOUT  out  RAM_WIDTH  head-of-stream data.
- DVALID  out  1  DOUT holds a valid word.
- DREADY  in  1  consumer accepts DOUT; a pop occurs when DVALID and DREADY are both high.
- EMPTY  out  1  no unfetched words remain in the memory.
- LEVEL  out  RAM_DEPTH+1  number of unfetched words in memory, taken from the synchronized view.

## Operation
- **Synchronizer:** two-flop synchronizer on WPTR_GRAY gives wsync_gray; convert it to binary wsync_bin.
- **Read pointer:** binary read pointer rbin, RAM_DEPTH+1 bits; RPTR_GRAY = rbin ^ (rbin>>1), registered.
- **EMPTY:** EMPTY = (rbin == wsync_bin), registered.
- **LEVEL:** LEVEL = (wsync_bin - rbin) mod 2^(RAM_DEPTH+1), registered.
- **Storage:** two slots, the output register (DOUT) and one skid register. Track:
  - occ, 0..2: occupied slots;
  - infl, 0..1: fetch issued last cycle whose RDATA arrives this cycle.
- **Fetch rule:** fetch when EMPTY=0 and (occ + infl - pop) < 2. On a fetch:
  - the memory captures BRAM[RADDR] on the same edge;
  - rbin increments, wrapping modulo 2^(RAM_DEPTH+1);
  - infl is set for the next cycle.
- **Arrival ordering:** when infl=1, RDATA enters the storage:
  - into DOUT if DOUT will be empty after this cycle's pop and the skid is empty;
  - otherwise into the skid.
- **Pop:** DOUT takes the skid word if the skid is valid, else the arriving RDATA, else DVALID falls.
- **Ordering:** words leave strictly in write order, with no duplication and no loss.
- **Simultaneous events:** pop, arrival and fetch may all occur in one cycle. The storage never exceeds 2 words and never overflows.
- **Pointer wrap:** the MSB toggle distinguishes full from empty; rbin == wsync_bin means empty even after wrap.
- **Reset:** all state clears asynchronously, including any in-flight fetch and stored words.
  - Reset values: rbin=0, RPTR_GRAY=0, sync flops=0, RADDR=0, DOUT=0, DVALID=0, EMPTY=1, LEVEL=0, occ=0, infl=0.
  - The write side must be reset in the same event. Resetting mid-operation drops all buffered data.

## Timing
- **Write-to-output latency:** a WPTR_GRAY change after edge 0 is seen as follows:
  - synchronized at edge 2;
  - EMPTY falls after edge 3;
  - fetch issued at edge 4;
  - RDATA valid in the following cycle;
  - DVALID high after edge 5, for 5 cycles total.
- **Throughput:** 1 word per cycle while DREADY=1 and the memory is non-empty.
- **Stall handling:** with DREADY=0, at most 2 words are fetched beyond the head. No fetch issues while occ + infl = 2.
- **Pointer update:** RPTR_GRAY updates the cycle after each fetch and changes by exactly one bit per update.
- **DVALID rule:** DVALID, once high, stays high with DOUT stable until popped.

## Test plan
- **Reset:** assert RST_N=0 mid-stream with 2 words buffered -> DVALID=0, EMPTY=1, RPTR_GRAY=0 immediately, before the next edge; no stale word after release.
- **Single word:** write 0xA5A5 at address 0, WPTR_GRAY 00000->00001 -> DVALID high 5 cycles later with DOUT=0xA5A5; after the pop, EMPTY=1 and RPTR_GRAY=00001.
- **Streaming:** write 16 words 0x0000..0x000F with DREADY held 1 -> 16 consecutive DVALID cycles, values in order, LEVEL returns to 0.
- **Backpressure:** write 8 words with DREADY=0 for 20 cycles -> exactly 2 fetches (rbin=2), LEVEL=6, DOUT=word0 stable. Release DREADY -> words 0..7 in order with no gaps after the first.
- **Wrap:** push 40 words through with random DREADY -> rbin wraps past 31 to 0, every RPTR_GRAY transition flips exactly one bit, data order is intact, and EMPTY=1 when wsync_bin equals rbin after the wrap.
- **Simultaneous events:** occ=1, infl=1, pop in the same cycle with a new fetch -> DOUT takes the arriving word, skid stays empty, occ=1, infl=1; no word lost or duplicated.
